// File: rtl/processing_element_os_mb.sv
// Output-stationary MAC processing element: zero-gated multiplier pipeline,
// NUM_ACC accumulator banks, operand forwarding and a result scan chain.
module processing_element_os_mb #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MAC = 48,
    parameter int WIDTH_T   = 2,
    parameter int STAGE     = 1,
    parameter int NUM_ACC   = 4,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0,
    localparam int ACC_W    = $clog2(NUM_ACC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_A-1:0]   act,
    input  logic [WIDTH_B-1:0]   wei,
    input  logic                 in_vld,
    input  logic [ACC_W-1:0]     acc_sel,
    input  logic                 acc_last,
    input  logic                 reg_clear,
    input  logic [WIDTH_T-1:0]   Thres,
    input  logic [WIDTH_MAC-1:0] scan_in,
    input  logic                 scan_in_vld,
    input  logic                 scan_shift,
    output logic [WIDTH_A-1:0]   act_out,
    output logic [WIDTH_B-1:0]   wei_out,
    output logic                 vld_out,
    output logic [ACC_W-1:0]     acc_sel_out,
    output logic                 acc_last_out,
    output logic [WIDTH_MAC-1:0] scan_out,
    output logic                 scan_out_vld,
    output logic                 done,
    output logic                 ovf,
    output logic                 overrun
);
    localparam int WP = WIDTH_A + WIDTH_B;

    // in_vld qualifies act/wei/acc_sel/acc_last in the same cycle; there is
    // no backpressure, every valid operand is consumed on the edge it is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_out <= '0; wei_out <= '0; acc_sel_out <= '0;
            acc_last_out <= 1'b0; vld_out <= 1'b0;
        end else if (reg_clear) begin
            act_out <= '0; wei_out <= '0; acc_sel_out <= '0;
            acc_last_out <= 1'b0; vld_out <= 1'b0;
        end else begin
            vld_out <= in_vld;
            if (in_vld) begin
                act_out      <= act;
                wei_out      <= wei;
                acc_sel_out  <= acc_sel;
                acc_last_out <= acc_last;
            end
        end
    end

    logic [WIDTH_A-1:0] act_mag;
    logic [WIDTH_B-1:0] wei_mag;
    logic               zero, sgn_a, sgn_b;
    logic [WP-1:0]      a_ext, b_ext, prod0;

    // A magnitude below 2^Thres has no bits left after shifting by Thres.
    always_comb begin
        sgn_a   = (SIGNED != 0) && act[WIDTH_A-1];
        sgn_b   = (SIGNED != 0) && wei[WIDTH_B-1];
        act_mag = sgn_a ? -act : act;
        wei_mag = sgn_b ? -wei : wei;
        zero    = ((act_mag >> Thres) == '0) || ((wei_mag >> Thres) == '0);
        a_ext   = '0;
        b_ext   = '0;
        if (!zero) begin
            a_ext = {{WIDTH_B{sgn_a}}, act};
            b_ext = {{WIDTH_A{sgn_b}}, wei};
        end
        prod0 = a_ext * b_ext;
    end

    logic             p_vld, p_last, p_zero;
    logic [ACC_W-1:0] p_sel;
    logic [WP-1:0]    p_prod;

    generate
        if (STAGE == 0) begin : g_comb
            always_comb begin
                p_vld = in_vld; p_last = acc_last; p_zero = zero;
                p_sel = acc_sel; p_prod = prod0;
            end
        end else begin : g_pipe
            logic [STAGE-1:0] vld_sr, last_sr, zero_sr;
            logic [ACC_W-1:0] sel_sr [STAGE];
            logic [WP-1:0]    prod_sr [STAGE];
            always_ff @(posedge clk or posedge rst) begin
                if (rst || reg_clear) begin
                    vld_sr <= '0; last_sr <= '0; zero_sr <= '0;
                    for (int i = 0; i < STAGE; i++) begin
                        sel_sr[i]  <= '0;
                        prod_sr[i] <= '0;
                    end
                end else begin
                    vld_sr[0] <= in_vld; last_sr[0] <= acc_last; zero_sr[0] <= zero;
                    sel_sr[0] <= acc_sel; prod_sr[0] <= prod0;
                    for (int i = 1; i < STAGE; i++) begin
                        vld_sr[i]  <= vld_sr[i-1];
                        last_sr[i] <= last_sr[i-1];
                        zero_sr[i] <= zero_sr[i-1];
                        sel_sr[i]  <= sel_sr[i-1];
                        prod_sr[i] <= prod_sr[i-1];
                    end
                end
            end
            always_comb begin
                p_vld = vld_sr[STAGE-1]; p_last = last_sr[STAGE-1]; p_zero = zero_sr[STAGE-1];
                p_sel = sel_sr[STAGE-1]; p_prod = prod_sr[STAGE-1];
            end
        end
    endgenerate

    logic [WIDTH_MAC-1:0] acc [NUM_ACC];
    logic [WIDTH_MAC-1:0] cur, addend, sum_raw, sum, new_val, pend;
    logic                 carry, add_ovf, fire, move, pend_vld;

    always_comb begin
        cur = acc[p_sel];
        if (SIGNED != 0) addend = WIDTH_MAC'($signed(p_prod));
        else             addend = WIDTH_MAC'(p_prod);
        {carry, sum_raw} = {1'b0, cur} + {1'b0, addend};
        if (SIGNED != 0)
            add_ovf = (cur[WIDTH_MAC-1] == addend[WIDTH_MAC-1]) &&
                      (sum_raw[WIDTH_MAC-1] != cur[WIDTH_MAC-1]);
        else
            add_ovf = carry;
        sum = sum_raw;
        if (add_ovf && SATURATE != 0) begin
            if (SIGNED != 0) sum = {cur[WIDTH_MAC-1], {(WIDTH_MAC-1){~cur[WIDTH_MAC-1]}}};
            else             sum = '1;
        end
        new_val = p_zero ? cur : sum;
        fire    = p_vld && p_last;
        move    = !scan_shift && !scan_out_vld && pend_vld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || reg_clear) begin
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            pend <= '0; pend_vld <= 1'b0; done <= 1'b0;
            ovf <= 1'b0; overrun <= 1'b0;
        end else begin
            done <= fire;
            if (p_vld) begin
                if (fire)         acc[p_sel] <= '0;
                else if (!p_zero) acc[p_sel] <= sum;
                if (!p_zero && add_ovf) ovf <= 1'b1;
            end
            // A result being handed to scan_out this cycle frees pend for the new one.
            if (fire) begin
                pend     <= new_val;
                pend_vld <= 1'b1;
                if (pend_vld && !move) overrun <= 1'b1;
            end else if (move) begin
                pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_out <= '0; scan_out_vld <= 1'b0;
        end else if (scan_shift) begin
            scan_out <= scan_in; scan_out_vld <= scan_in_vld;
        end else if (!reg_clear && move) begin
            scan_out <= pend; scan_out_vld <= 1'b1;
        end
    end
endmodule

// File: tb/tb_processing_element_os_mb.sv
// Bench for processing_element_os_mb: three configurations share one stimulus
// stream and are checked every cycle against an arithmetic model.
module tb_processing_element_os_mb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] act = '0, wei = '0;
    logic        in_vld = 1'b0, acc_last = 1'b0, reg_clear = 1'b0;
    logic [1:0]  acc_sel = '0, thres = '0;
    logic [47:0] scan_in = '0;
    logic        scan_in_vld = 1'b0, scan_shift = 1'b0;

    logic [15:0] u_act, u_wei, s_act, s_wei, w_act, w_wei;
    logic [1:0]  u_sel, s_sel, w_sel;
    logic        u_vld, u_last, u_svld, u_done, u_ovf, u_ovr;
    logic        s_vld, s_last, s_svld, s_done, s_ovf, s_ovr;
    logic        w_vld, w_last, w_svld, w_done, w_ovf, w_ovr;
    logic [47:0] u_scan;
    logic [31:0] s_scan, w_scan;

    int n_vec = 0;
    int n_miss = 0;
    int done_cnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    processing_element_os_mb #(.STAGE(1)) dut_u (
        .clk(clk), .rst(rst), .act(act), .wei(wei), .in_vld(in_vld), .acc_sel(acc_sel),
        .acc_last(acc_last), .reg_clear(reg_clear), .Thres(thres), .scan_in(scan_in),
        .scan_in_vld(scan_in_vld), .scan_shift(scan_shift), .act_out(u_act), .wei_out(u_wei),
        .vld_out(u_vld), .acc_sel_out(u_sel), .acc_last_out(u_last), .scan_out(u_scan),
        .scan_out_vld(u_svld), .done(u_done), .ovf(u_ovf), .overrun(u_ovr));

    processing_element_os_mb #(.WIDTH_MAC(32), .STAGE(2), .SIGNED(1), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .act(act), .wei(wei), .in_vld(in_vld), .acc_sel(acc_sel),
        .acc_last(acc_last), .reg_clear(reg_clear), .Thres(thres), .scan_in(scan_in[31:0]),
        .scan_in_vld(scan_in_vld), .scan_shift(scan_shift), .act_out(s_act), .wei_out(s_wei),
        .vld_out(s_vld), .acc_sel_out(s_sel), .acc_last_out(s_last), .scan_out(s_scan),
        .scan_out_vld(s_svld), .done(s_done), .ovf(s_ovf), .overrun(s_ovr));

    processing_element_os_mb #(.WIDTH_MAC(32), .STAGE(2), .SIGNED(1), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .act(act), .wei(wei), .in_vld(in_vld), .acc_sel(acc_sel),
        .acc_last(acc_last), .reg_clear(reg_clear), .Thres(thres), .scan_in(scan_in[31:0]),
        .scan_in_vld(scan_in_vld), .scan_shift(scan_shift), .act_out(w_act), .wei_out(w_wei),
        .vld_out(w_vld), .acc_sel_out(w_sel), .acc_last_out(w_last), .scan_out(w_scan),
        .scan_out_vld(w_svld), .done(w_done), .ovf(w_ovf), .overrun(w_ovr));

    // ---------------- model: k=0 unsigned/48b/stage1, k=1 signed sat/32b/stage2, k=2 signed wrap/32b/stage2
    typedef struct packed {
        bit       vld;
        bit       last;
        bit       zero;
        logic [1:0] sel;
        longint   prod;
    } op_t;

    longint      m_acc[3][4];
    longint      m_pend[3], m_scan[3];
    bit          m_pvld[3], m_svld[3], m_done[3], m_ovf[3], m_ovr[3], m_vld[3], m_last[3];
    logic [15:0] m_act[3], m_wei[3];
    logic [1:0]  m_sel[3];
    op_t         dl[3][2];

    function automatic int stg(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic longint modw(int k);
        return (k == 0) ? (longint'(1) << 48) : (longint'(1) << 32);
    endfunction

    function automatic longint opval(int k, logic [15:0] x);
        if (k != 0) return longint'($signed(x));
        return longint'(x);
    endfunction

    function automatic bit gated(int k, logic [15:0] a, logic [15:0] w, logic [1:0] th);
        longint ma, mw, lim;
        ma = opval(k, a);
        mw = opval(k, w);
        if (ma < 0) ma = -ma;
        if (mw < 0) mw = -mw;
        lim = longint'(1) << th;
        return (ma < lim) || (mw < lim);
    endfunction

    task automatic model_step(input int k);
        op_t    nw, o;
        longint md, half, cur, full, lo, hi, res, old_pend;
        bit     mv, fire, old_pvld;
        md = modw(k);
        half = md / 2;
        nw.vld  = in_vld;
        nw.last = acc_last;
        nw.sel  = acc_sel;
        nw.zero = gated(k, act, wei, thres);
        if (nw.zero) nw.prod = 0;
        else         nw.prod = opval(k, act) * opval(k, wei);
        o = dl[k][stg(k)-1];
        dl[k][1] = dl[k][0];
        dl[k][0] = nw;
        old_pend = m_pend[k];
        old_pvld = m_pvld[k];
        mv   = !scan_shift && !m_svld[k] && old_pvld;
        fire = o.vld && o.last;
        res  = m_acc[k][o.sel];
        if (o.vld && !o.zero) begin
            cur = res;
            if (k != 0 && cur >= half) cur = cur - md;
            full = cur + o.prod;
            if (k != 0) begin lo = -half; hi = half - 1; end
            else begin lo = 0; hi = md - 1; end
            if (full > hi || full < lo) begin
                m_ovf[k] = 1'b1;
                if (k == 1) full = (full > hi) ? hi : lo;
            end
            res = ((full % md) + md) % md;
            m_acc[k][o.sel] = res;
        end
        if (fire) begin
            if (old_pvld && !mv) m_ovr[k] = 1'b1;
            m_pend[k] = res;
            m_acc[k][o.sel] = 0;
        end
        m_pvld[k] = fire || (old_pvld && !mv);
        if (scan_shift) begin
            m_scan[k] = longint'(scan_in) & (md - 1);
            m_svld[k] = scan_in_vld;
        end else if (mv) begin
            m_scan[k] = old_pend;
            m_svld[k] = 1'b1;
        end
        m_done[k] = fire;
        m_vld[k]  = in_vld;
        if (in_vld) begin
            m_act[k] = act; m_wei[k] = wei; m_sel[k] = acc_sel; m_last[k] = acc_last;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst || reg_clear) begin
                for (int b = 0; b < 4; b++) m_acc[k][b] = 0;
                m_pend[k] = 0; m_pvld[k] = 0; m_done[k] = 0; m_ovf[k] = 0; m_ovr[k] = 0;
                m_act[k] = '0; m_wei[k] = '0; m_vld[k] = 0; m_sel[k] = '0; m_last[k] = 0;
                dl[k][0] = '0; dl[k][1] = '0;
                if (rst) begin
                    m_scan[k] = 0; m_svld[k] = 0;
                end else if (scan_shift) begin
                    m_scan[k] = longint'(scan_in) & (modw(k) - 1);
                    m_svld[k] = scan_in_vld;
                end
            end else begin
                model_step(k);
            end
        end
    end

    // ---------------- scoreboard
    task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", nm, k, $time, got, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input logic [15:0] a, input logic [15:0] w,
                            input logic v, input logic [1:0] s, input logic l,
                            input logic [47:0] sc, input logic sv, input logic d,
                            input logic o, input logic r);
        chk("act_out", k, a, m_act[k]);
        chk("wei_out", k, w, m_wei[k]);
        chk("vld_out", k, v, m_vld[k]);
        chk("acc_sel_out", k, s, m_sel[k]);
        chk("acc_last_out", k, l, m_last[k]);
        chk("scan_out", k, sc, m_scan[k]);
        chk("scan_out_vld", k, sv, m_svld[k]);
        chk("done", k, d, m_done[k]);
        chk("ovf", k, o, m_ovf[k]);
        chk("overrun", k, r, m_ovr[k]);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, u_act, u_wei, u_vld, u_sel, u_last, u_scan, u_svld, u_done, u_ovf, u_ovr);
        cmp_inst(1, s_act, s_wei, s_vld, s_sel, s_last, {16'b0, s_scan}, s_svld, s_done, s_ovf, s_ovr);
        cmp_inst(2, w_act, w_wei, w_vld, w_sel, w_last, {16'b0, w_scan}, w_svld, w_done, w_ovf, w_ovr);
        if (u_done === 1'b1) done_cnt[0]++;
        if (s_done === 1'b1) done_cnt[1]++;
        if (w_done === 1'b1) done_cnt[2]++;
    end

    // ---------------- drivers
    task automatic op(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] w,
                      input logic last, input logic [1:0] th);
        @(negedge clk);
        in_vld = 1'b1; acc_sel = sel; act = a; wei = w; acc_last = last; thres = th;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_vld = 1'b0; acc_last = 1'b0;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        in_vld = 1'b0; acc_last = 1'b0; scan_shift = 1'b1;
        @(negedge clk);
        scan_shift = 1'b0;
    endtask

    task automatic chk_scan(input string nm, input logic [47:0] eu, input logic [31:0] es,
                            input logic [31:0] ew);
        chk(nm, 0, u_scan, eu);
        chk(nm, 1, s_scan, es);
        chk(nm, 2, w_scan, ew);
        chk({nm, "_vld"}, 0, u_svld, 1'b1);
        chk({nm, "_vld"}, 1, s_svld, 1'b1);
        chk({nm, "_vld"}, 2, w_svld, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_scan", 0, u_scan, 48'd0);
        chk("rst_done", 1, s_done, 1'b0);
        chk("rst_vld_out", 2, w_vld, 1'b0);
        rst = 1'b0;
        idle(1);

        // three-operand tile on bank 0: 1*4 + 2*5 + 3*6
        op(2'd0, 16'd1, 16'd4, 1'b0, 2'd0);
        op(2'd0, 16'd2, 16'd5, 1'b0, 2'd0);
        op(2'd0, 16'd3, 16'd6, 1'b1, 2'd0);
        idle(6);
        chk_scan("tile_sum", 48'd32, 32'd32, 32'd32);
        for (int k = 0; k < 3; k++) chk("done_count", k, done_cnt[k], 1);
        drain();

        // zero gating: 3 is below 2^2; -2 is gated only when operands are signed
        op(2'd2, 16'd3, 16'd100, 1'b0, 2'd2);
        idle(1);
        chk("fwd_act", 0, u_act, 16'd3);
        chk("fwd_wei", 1, s_wei, 16'd100);
        op(2'd2, 16'hFFFE, 16'd5, 1'b0, 2'd2);
        op(2'd2, 16'd1, 16'd7, 1'b1, 2'd0);
        idle(6);
        chk_scan("gated_sum", 48'd327677, 32'd7, 32'd7);
        drain();

        // interleaved banks, results come out in issue order
        op(2'd0, 16'd3, 16'd3, 1'b0, 2'd0);
        op(2'd1, 16'd2, 16'd2, 1'b0, 2'd0);
        op(2'd0, 16'd1, 16'd1, 1'b1, 2'd0);
        op(2'd1, 16'd5, 16'd5, 1'b1, 2'd0);
        idle(6);
        chk_scan("bank0_sum", 48'd10, 32'd10, 32'd10);
        drain();
        idle(2);
        chk_scan("bank1_sum", 48'd29, 32'd29, 32'd29);
        chk("no_overrun", 1, s_ovr, 1'b0);
        drain();

        // two results while the chain is shifting: second overwrites the first
        @(negedge clk);
        scan_shift = 1'b1;
        op(2'd3, 16'd2, 16'd3, 1'b1, 2'd0);
        op(2'd3, 16'd4, 16'd5, 1'b1, 2'd0);
        idle(6);
        chk("overrun", 0, u_ovr, 1'b1);
        chk("overrun", 2, w_ovr, 1'b1);
        scan_shift = 1'b0;
        idle(3);
        chk_scan("overrun_pend", 48'd20, 32'd20, 32'd20);
        drain();

        // build 0x7FFFFFF0 then add 0x20: saturate vs wrap at 32 bits
        op(2'd0, 16'h8000, 16'h8000, 1'b0, 2'd0);
        op(2'd0, 16'h7FFF, 16'h7FFF, 1'b0, 2'd0);
        op(2'd0, 16'h7FFF, 16'd1, 1'b0, 2'd0);
        op(2'd0, 16'h07FF, 16'd16, 1'b0, 2'd0);
        op(2'd0, 16'd4, 16'd8, 1'b1, 2'd0);
        idle(6);
        chk_scan("ovf_sum", 48'h0000_8000_0010, 32'h7FFF_FFFF, 32'h8000_0010);
        chk("ovf_flag", 0, u_ovf, 1'b0);
        chk("ovf_flag", 1, s_ovf, 1'b1);
        chk("ovf_flag", 2, w_ovf, 1'b1);
        drain();

        // synchronous clear drops in-flight operands and sticky flags
        op(2'd1, 16'd9, 16'd9, 1'b0, 2'd0);
        op(2'd1, 16'd9, 16'd9, 1'b0, 2'd0);
        @(negedge clk);
        in_vld = 1'b0; reg_clear = 1'b1;
        @(negedge clk);
        reg_clear = 1'b0;
        chk("clr_act_out", 0, u_act, 16'd0);
        chk("clr_ovf", 1, s_ovf, 1'b0);
        op(2'd1, 16'd2, 16'd3, 1'b1, 2'd0);
        idle(6);
        chk_scan("clr_sum", 48'd6, 32'd6, 32'd6);

        // asynchronous reset with a full pipeline
        op(2'd0, 16'd1, 16'd1, 1'b0, 2'd0);
        op(2'd0, 16'd1, 16'd1, 1'b0, 2'd0);
        op(2'd0, 16'd1, 16'd1, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_act_out", 0, u_act, 16'd0);
        chk("arst_vld_out", 1, s_vld, 1'b0);
        chk("arst_scan", 2, w_scan, 32'd0);
        chk("arst_scan_vld", 0, u_svld, 1'b0);
        chk("arst_ovf", 2, w_ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0; in_vld = 1'b0;
        op(2'd0, 16'd3, 16'd4, 1'b1, 2'd0);
        idle(6);
        chk_scan("post_rst_sum", 48'd12, 32'd12, 32'd12);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
